// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling-free UART receiver with configurable framing and a one-entry valid/ready output register.
// After a break frame (all data low, stop low) the receiver stays disarmed until rx_s is seen high again.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam logic [31:0] DIV_M1 = 32'(DIV - 1);
    localparam logic [31:0] HALF_M1 = 32'(HALF - 1);
    localparam logic [3:0] DB_M1 = 4'(DATA_BITS - 1);
    localparam logic [3:0] SB_M1 = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, COMMIT} state_t;

    state_t               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 armed_q, armed_d, load_q, load_d;
    logic                 valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
    logic                 s1_q, s2_q;
    logic                 rx_s;

    assign rx_s = s2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        armed_d = armed_q | rx_s;
        load_d  = 1'b0;
        valid_d = load_q | (valid_q & ~ready);
        ovr_d   = (ovr_q & ~(valid_q & ready)) | (load_q & valid_q & ~ready);
        data_d  = data_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        if (load_q && (!valid_q || ready)) begin
            data_d = sh_q;
            pe_d   = perr_q;
            fe_d   = ferr_q;
        end
        case (state_q)
            IDLE: if (!rx_s && armed_q) begin
                state_d = START;
                cnt_d   = '0;
            end
            START: if (cnt_q == HALF_M1) begin
                state_d = rx_s ? IDLE : DATA;
                cnt_d   = '0;
                idx_d   = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
            end
            DATA: if (cnt_q == DIV_M1) begin
                cnt_d = '0;
                sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
                idx_d = (idx_q == DB_M1) ? 4'd0 : idx_q + 4'd1;
                if (idx_q == DB_M1) state_d = (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (cnt_q == DIV_M1) begin
                cnt_d   = '0;
                perr_d  = (^sh_q) ^ rx_s ^ (PARITY == 1);
                state_d = STOP;
            end
            STOP: if (cnt_q == DIV_M1) begin
                cnt_d  = '0;
                ferr_d = ferr_q | ~rx_s;
                idx_d  = idx_q + 4'd1;
                if (idx_q == SB_M1) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                load_d  = 1'b1;
                armed_d = !((sh_q == '0) && ferr_q);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b1;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            load_q  <= load_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
            s1_q    <= rx;
            s2_q    <= s1_q;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = (PARITY != 0) ? pe_q : 1'b0;
    assign frame_err  = fe_q;
    assign overrun    = ovr_q;
    assign busy       = state_q != IDLE;
endmodule
